// File: rtl/ssm2603_i2s_adc_receiver.sv
// ssm2603_i2s_adc_receiver
// Deserialises the SSM2603 ADC I2S stream (slave to the FPGA-generated
// bclk/lrclk) into left-justified left/right words with a frame strobe.
// Ports:
//   clk, rst            system clock, async active-high reset
//   bclk, lrclk, adcdat I2S inputs (lrclk low = left channel)
//   left, right         last complete channel words (signed, MSB-aligned)
//   value               channel selected by mono_channel, updated at its commit
//   valid               one-cycle pulse on each right-word commit (full L+R frame)
//   short_word          one-cycle pulse when a committed half-frame had < w_sample bits
module ssm2603_i2s_adc_receiver #(
  parameter int unsigned w_sample     = 24,
  parameter int unsigned mono_channel = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic                adcdat,
  output logic [w_sample-1:0] left,
  output logic [w_sample-1:0] right,
  output logic [w_sample-1:0] value,
  output logic                valid,
  output logic                short_word
);

  localparam int unsigned CNT_W = $clog2(w_sample + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_dat_s1, r_dat_s2;
  logic r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic r_lr_s1, r_lr_s2, r_lr_d;

  logic [w_sample-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_bclk_rise;
  logic                w_lr_edge;
  logic                w_lr_fell;
  logic                w_short;
  logic                w_commit;
  logic                w_shift_en;
  logic [w_sample-1:0] w_word;

  // Identical two-flop chains keep data, bit clock and word clock aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat_s1  <= 1'b0;
      r_dat_s2  <= 1'b0;
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_d    <= 1'b0;
    end else begin
      r_dat_s1  <= adcdat;
      r_dat_s2  <= r_dat_s1;
      r_bclk_s1 <= bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lr_s1   <= lrclk;
      r_lr_s2   <= r_lr_s1;
      r_lr_d    <= r_lr_s2;
    end
  end

  assign w_bclk_rise = r_bclk_s2 & ~r_bclk_d;
  assign w_lr_edge   = r_lr_s2 ^ r_lr_d;
  assign w_lr_fell   = r_lr_d & ~r_lr_s2;
  assign w_short     = (r_cnt < CNT_W'(w_sample));
  // Left-justify the captured bits; a zero count yields an all-zero word.
  assign w_word      = r_shreg << (CNT_W'(w_sample) - r_cnt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and datapath controls. A bclk rise coincident with an lrclk
  // edge is taken as the one-bit delay slot of the new half-frame.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_lr_fell) w_state_next = w_bclk_rise ? SHIFT : DELAY;
      end
      DELAY: begin
        if (w_lr_edge) begin
          w_commit     = 1'b1;
          w_state_next = w_bclk_rise ? SHIFT : DELAY;
        end else if (w_bclk_rise) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_lr_edge) begin
          w_commit     = 1'b1;
          w_state_next = w_bclk_rise ? SHIFT : DELAY;
        end else if (w_bclk_rise && w_short) begin
          w_shift_en = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register, bit counter and output words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      left       <= '0;
      right      <= '0;
      value      <= '0;
      valid      <= 1'b0;
      short_word <= 1'b0;
    end else begin
      valid      <= 1'b0;
      short_word <= 1'b0;
      if (w_commit) begin
        r_shreg    <= '0;
        r_cnt      <= '0;
        short_word <= w_short;
        if (r_lr_s2) begin
          // lrclk rose: the left half-frame just ended
          left <= w_word;
          if (mono_channel == 0) value <= w_word;
        end else begin
          right <= w_word;
          valid <= 1'b1;
          if (mono_channel != 0) value <= w_word;
        end
      end else if (w_shift_en) begin
        r_shreg <= {r_shreg[w_sample-2:0], r_dat_s2};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ssm2603_i2s_adc_receiver.sv
// Testbench for ssm2603_i2s_adc_receiver: drives I2S half-frames from tables
// and directed sequences into a left-mono and a right-mono instance.
module tb_ssm2603_i2s_adc_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk_i, lr_i, dat_i;
  logic [23:0] l0, r0, v0, l1, r1, v1;
  logic        vld0, vld1, sw0, sw1;

  always #10 clk = ~clk;

  ssm2603_i2s_adc_receiver #(.w_sample(24), .mono_channel(0)) dut0 (
    .clk(clk), .rst(rst), .bclk(bclk_i), .lrclk(lr_i), .adcdat(dat_i),
    .left(l0), .right(r0), .value(v0), .valid(vld0), .short_word(sw0)
  );

  ssm2603_i2s_adc_receiver #(.w_sample(24), .mono_channel(1)) dut1 (
    .clk(clk), .rst(rst), .bclk(bclk_i), .lrclk(lr_i), .adcdat(dat_i),
    .left(l1), .right(r1), .value(v1), .valid(vld1), .short_word(sw1)
  );

  typedef struct {
    int          slot_len;
    int          nbits;
    logic [23:0] lw;
    logic [23:0] rw;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic [23:0] exp_v0;
    logic [23:0] exp_v1;
    int          exp_short;
  } vec_t;

  vec_t        vecs [7];
  int          n_chk = 0;
  int          n_err = 0;
  int          hp = 8;

  // Monitor: capture outputs at every valid pulse.
  int          n_vld = 0;
  int          n_sw = 0;
  int          n_bad = 0;
  logic        prev_vld = 1'b0;
  logic [23:0] cap_l  [256];
  logic [23:0] cap_r  [256];
  logic [23:0] cap_v0 [256];
  logic [23:0] cap_v1 [256];
  logic [23:0] el [100];
  logic [23:0] er [100];

  always @(negedge clk) begin
    if (vld0 === 1'b1) begin
      cap_l[n_vld[7:0]]  = l0;
      cap_r[n_vld[7:0]]  = r0;
      cap_v0[n_vld[7:0]] = v0;
      cap_v1[n_vld[7:0]] = v1;
      n_vld++;
    end
    if (sw0 === 1'b1) n_sw++;
    if (vld0 === 1'b1 && prev_vld === 1'b1) n_bad++;
    if (vld0 !== vld1 || sw0 !== sw1 || l0 !== l1 || r0 !== r1) n_bad++;
    prev_vld = vld0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bclk period: data (and normally lrclk) change on the falling edge;
  // in coincident mode lrclk changes with the rising edge instead.
  task automatic slot(input logic lr, input logic d, input bit co);
    bclk_i = 1'b0;
    dat_i  = d;
    if (!co) lr_i = lr;
    repeat (hp) @(posedge clk);
    #1;
    bclk_i = 1'b1;
    if (co) lr_i = lr;
    repeat (hp) @(posedge clk);
    #1;
  endtask

  // Half-frame of s slots: slot 0 is the delay slot (driven 1), slots 1..n
  // carry the n-bit word MSB first, later slots are padded with 1s.
  task automatic half(input logic lr, input logic [23:0] w, input int n, input int s, input bit co);
    for (int k = 0; k < s; k++) begin
      logic d;
      if (k >= 1 && k <= n) d = w[n-k];
      else                  d = 1'b1;
      slot(lr, d, co);
    end
  endtask

  task automatic do_reset(input logic lr0, input string tag);
    rst    = 1'b1;
    bclk_i = 1'b0;
    lr_i   = lr0;
    dat_i  = 1'b0;
    #1;
    chk({tag, "_rst_left"},  32'(l0), 32'h0);
    chk({tag, "_rst_right"}, 32'(r0), 32'h0);
    chk({tag, "_rst_value"}, 32'(v0), 32'h0);
    chk({tag, "_rst_value1"}, 32'(v1), 32'h0);
    chk({tag, "_rst_valid"}, 32'(vld0), 32'h0);
    chk({tag, "_rst_short"}, 32'(sw0), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [23:0] el_x,
                             input logic [23:0] er_x, input logic [23:0] ev0, input logic [23:0] ev1);
    chk($sformatf("%s_left[%0d]", tag, idx),   32'(cap_l[idx[7:0]]),  32'(el_x));
    chk($sformatf("%s_right[%0d]", tag, idx),  32'(cap_r[idx[7:0]]),  32'(er_x));
    chk($sformatf("%s_value0[%0d]", tag, idx), 32'(cap_v0[idx[7:0]]), 32'(ev0));
    chk($sformatf("%s_value1[%0d]", tag, idx), 32'(cap_v1[idx[7:0]]), 32'(ev1));
  endtask

  initial begin
    int base;
    int sbase;

    // slot_len, nbits, lw, rw, exp_l, exp_r, exp_v0, exp_v1, exp_short
    vecs[0] = '{32, 24, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 0};
    vecs[1] = '{17, 16, 24'h008001, 24'h007FFE, 24'h800100, 24'h7FFE00, 24'h800100, 24'h7FFE00, 1};
    vecs[2] = '{32, 24, 24'h800000, 24'h000001, 24'h800000, 24'h000001, 24'h800000, 24'h000001, 0};
    vecs[3] = '{ 9,  8, 24'h0000A5, 24'h00003C, 24'hA50000, 24'h3C0000, 24'hA50000, 24'h3C0000, 1};
    vecs[4] = '{25, 24, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 0};
    vecs[5] = '{ 1,  0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1};
    vecs[6] = '{24, 23, 24'h400001, 24'h3FFFFF, 24'h800002, 24'h7FFFFE, 24'h800002, 24'h7FFFFE, 1};

    rst = 1'b1; bclk_i = 1'b0; lr_i = 1'b0; dat_i = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven: two frames per vector, then a trailing left slot to close the last right word.
    for (int i = 0; i < 7; i++) begin
      do_reset(1'b0, $sformatf("vec%0d", i));
      hp = 8;
      slot(1'b1, 1'b1, 1'b0);
      slot(1'b1, 1'b1, 1'b0);
      base  = n_vld;
      sbase = n_sw;
      repeat (2) begin
        half(1'b0, vecs[i].lw, vecs[i].nbits, vecs[i].slot_len, 1'b0);
        half(1'b1, vecs[i].rw, vecs[i].nbits, vecs[i].slot_len, 1'b0);
      end
      slot(1'b0, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_count", i), 32'(n_vld - base), 32'd2);
      chk($sformatf("vec%0d_short_count", i), 32'(n_sw - sbase), 32'(4 * vecs[i].exp_short));
      for (int j = 0; j < 2; j++)
        check_frame($sformatf("vec%0d", i), base + j, vecs[i].exp_l, vecs[i].exp_r,
                    vecs[i].exp_v0, vecs[i].exp_v1);
    end

    // Reset mid-left-word, released while lrclk is high.
    do_reset(1'b0, "midrst");
    slot(1'b1, 1'b1, 1'b0);
    slot(1'b1, 1'b1, 1'b0);
    base = n_vld;
    for (int k = 0; k < 12; k++) slot(1'b0, k[0], 1'b0);
    #5 rst = 1'b1;
    for (int k = 0; k < 2; k++) slot(1'b1, 1'b1, 1'b0);
    #5 rst = 1'b0;
    for (int k = 0; k < 10; k++) slot(1'b1, k[0], 1'b0);
    chk("midrst_left_held",  32'(l0), 32'h0);
    chk("midrst_right_held", 32'(r0), 32'h0);
    chk("midrst_no_valid",   32'(n_vld - base), 32'd0);
    half(1'b0, 24'hABCDEF, 24, 32, 1'b0);
    half(1'b1, 24'h135790, 24, 32, 1'b0);
    slot(1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_valid_count", 32'(n_vld - base), 32'd1);
    check_frame("midrst", base, 24'hABCDEF, 24'h135790, 24'hABCDEF, 24'h135790);

    // Stream starts in the middle of a right half after reset.
    do_reset(1'b1, "midright");
    base = n_vld;
    for (int k = 0; k < 10; k++) slot(1'b1, ~k[0], 1'b0);
    half(1'b0, 24'h5A5A5A, 24, 32, 1'b0);
    half(1'b1, 24'hA5A5A5, 24, 32, 1'b0);
    slot(1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("midright_valid_count", 32'(n_vld - base), 32'd1);
    check_frame("midright", base, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5);

    // 100 random frames, lrclk edge coincident with bclk rise, fastest bclk.
    do_reset(1'b0, "rand");
    hp = 4;
    slot(1'b1, 1'b1, 1'b1);
    slot(1'b1, 1'b1, 1'b1);
    base = n_vld;
    for (int f = 0; f < 100; f++) begin
      el[f] = 24'($urandom);
      er[f] = 24'($urandom);
      half(1'b0, el[f], 24, 26, 1'b1);
      half(1'b1, er[f], 24, 26, 1'b1);
    end
    slot(1'b0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("rand_valid_count", 32'(n_vld - base), 32'd100);
    for (int f = 0; f < 100; f++)
      check_frame("rand", base + f, el[f], er[f], el[f], er[f]);

    chk("valid_b2b_or_instance_diff", 32'(n_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
